// File: rtl/raymarch_pkg.sv
// raymarch_pkg: shared types and widths for the raymarcher pixel path.
package raymarch_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} dispatch_state_t;
  localparam int RGB_W = 24;
  localparam int COORD_W = 33;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: raster-order x/y counters plus a running framebuffer address.
module raster_counter #(
  parameter int WIDTH = 300,
  parameter int HEIGHT = 300,
  parameter int XW = 9,
  parameter int YW = 9,
  parameter int AW = 17
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] a_q, a_d;
  logic          last_x, zero;
  assign last_x = x_q == XW'(WIDTH - 1);
  assign last_o = last_x && y_q == YW'(HEIGHT - 1);
  // Wrapping to zero after the final pixel keeps the address equal to y*WIDTH+x.
  assign zero = clr_i || (inc_i && last_o);
  always_comb begin
    x_d = zero ? '0 : inc_i ? (last_x ? '0 : x_q + 1'b1) : x_q;
    y_d = zero ? '0 : (inc_i && last_x) ? y_q + 1'b1 : y_q;
    a_d = zero ? '0 : inc_i ? a_q + 1'b1 : a_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
      a_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      a_q <= a_d;
    end
  end
  assign x_o = x_q;
  assign y_o = y_q;
  assign addr_o = a_q;
endmodule

// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher: walks a frame in raster order, feeds the raymarcher and writes results to the framebuffer.
// Optional per-pixel timeout with fallback colour is enabled by PIXEL_DISPATCH_TIMEOUT_EN.
module pixel_dispatcher
  import raymarch_pkg::*;
#(
  parameter int                WIDTH = 300,
  parameter int                HEIGHT = 300,
  parameter int                TIMEOUT = 4096,
  parameter logic [RGB_W-1:0]  FALLBACK_RGB = 24'hFF00FF,
  localparam int               AW = $clog2(WIDTH * HEIGHT)
) (
  input  logic               clk_pixel_in,
  input  logic               rst_in,
  input  logic               start_in,
  output logic               busy_out,
  output logic               frame_done_out,
  output logic [COORD_W-1:0] curr_x,
  output logic [COORD_W-1:0] curr_y,
  output logic               ray_start_out,
  input  logic               pixel_done,
  input  logic [7:0]         red_in,
  input  logic [7:0]         green_in,
  input  logic [7:0]         blue_in,
  output logic [AW-1:0]      fb_addr_out,
  output logic [RGB_W-1:0]   fb_data_out,
  output logic               fb_we_out,
  output logic [15:0]        timeout_count_out
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  dispatch_state_t  state_q;
  logic             busy_q, done_q, ray_q, we_q;
  logic [RGB_W-1:0] data_q;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             last, clr;
  // A start coinciding with frame_done is dropped so every frame needs a fresh request in IDLE.
  assign clr = state_q == IDLE && start_in && !done_q;
  raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW), .AW(AW)) u_raster (
    .clk_i(clk_pixel_in),
    .rst_ni(rst_in),
    .clr_i(clr),
    .inc_i(state_q == WRITE),
    .x_o(x),
    .y_o(y),
    .addr_o(fb_addr_out),
    .last_o(last)
  );
`ifdef PIXEL_DISPATCH_TIMEOUT_EN
  logic [15:0] wcnt_q, tcnt_q;
  assign timeout_count_out = tcnt_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(TIMEOUT), FALLBACK_RGB};
  assign timeout_count_out = '0;
`endif
  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ray_q <= 1'b0;
      we_q <= 1'b0;
      data_q <= '0;
`ifdef PIXEL_DISPATCH_TIMEOUT_EN
      wcnt_q <= '0;
      tcnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      ray_q <= 1'b0;
      we_q <= 1'b0;
      case (state_q)
        IDLE: if (clr) begin
          state_q <= ISSUE;
          busy_q <= 1'b1;
          ray_q <= 1'b1;
`ifdef PIXEL_DISPATCH_TIMEOUT_EN
          tcnt_q <= '0;
`endif
        end
        ISSUE: begin
          state_q <= WAIT;
`ifdef PIXEL_DISPATCH_TIMEOUT_EN
          wcnt_q <= '0;
`endif
        end
        WAIT: if (pixel_done) begin
          data_q <= {red_in, green_in, blue_in};
          state_q <= WRITE;
          we_q <= 1'b1;
        end
`ifdef PIXEL_DISPATCH_TIMEOUT_EN
        else if (wcnt_q == 16'(TIMEOUT - 1)) begin
          data_q <= FALLBACK_RGB;
          tcnt_q <= tcnt_q + {15'd0, ~&tcnt_q};
          state_q <= WRITE;
          we_q <= 1'b1;
        end else wcnt_q <= wcnt_q + 16'd1;
`endif
        WRITE: if (last) begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          state_q <= ISSUE;
          ray_q <= 1'b1;
        end
      endcase
    end
  end
  assign busy_out = busy_q;
  assign frame_done_out = done_q;
  assign ray_start_out = ray_q;
  assign fb_we_out = we_q;
  assign fb_data_out = data_q;
  assign curr_x = COORD_W'(x);
  assign curr_y = COORD_W'(y);
endmodule
